// File: rtl/axi4l_slave_regfile.sv
// AXI4-Lite slave register file.
// Purpose: NUM_REGS x DATA_WIDTH registers behind an AXI4-Lite slave port.
//   Registers flagged in RO_MASK reject writes (SLVERR) and return the
//   matching ro_i slice on reads. Out-of-range accesses answer SLVERR, RDATA=0.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   AW*/W*/B*       : write address / data / response channels
//   AR*/R*          : read address / data channels
//   regs_o          : all register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ro_i            : read-back values for read-only registers, same packing
module axi4l_slave_regfile #(
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFSET     = $clog2(STRB_WIDTH);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  ready_en;
  logic [0:0]            w_state;
  logic [0:0]            r_state;
  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_WIDTH-1:0] c_strb;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  c_in_range;
  logic                  c_ro;
  logic                  c_ok;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_in_range;
  logic [DATA_WIDTH-1:0] r_val;

  // ready_en holds all readies low during reset and lets them rise on the
  // first clock edge after release.
  assign AWREADY = ready_en && (w_state == W_IDLE) && !aw_done;
  assign WREADY  = ready_en && (w_state == W_IDLE) && !w_done;
  assign ARREADY = ready_en && (r_state == R_IDLE);

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // The write commits on the edge that completes the AW/W pair, using
  // whichever half arrives live on that edge. Results are visible the next
  // cycle, which keeps back-to-back writes at one per two cycles.
  assign c_addr = aw_done ? aw_addr : AWADDR;
  assign c_data = w_done  ? w_data  : WDATA;
  assign c_strb = w_done  ? w_strb  : WSTRB;
  assign commit = (w_state == W_IDLE) && (aw_done || aw_fire) && (w_done || w_fire);

  assign c_idx      = c_addr >> OFFSET;
  assign c_in_range = 32'(c_idx) < NUM_REGS;
  assign c_ok       = c_in_range && !c_ro;

  assign r_idx      = ARADDR >> OFFSET;
  assign r_in_range = 32'(r_idx) < NUM_REGS;

  always_comb begin
    c_ro  = 1'b0;
    r_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (c_idx == ADDR_WIDTH'(i)) c_ro = RO_MASK[i];
      if (r_idx == ADDR_WIDTH'(i))
        r_val = RO_MASK[i] ? ro_i[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && c_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (c_idx == ADDR_WIDTH'(i)) begin
          for (int unsigned k = 0; k < STRB_WIDTH; k++)
            if (c_strb[k]) regs[i][k*8 +: 8] <= c_data[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      BVALID  <= 1'b0;
      BRESP   <= '0;
    end else if (w_state == W_IDLE) begin
      if (commit) begin
        BVALID  <= 1'b1;
        BRESP   <= c_ok ? RESP_OKAY : RESP_SLVERR;
        w_state <= W_RESP;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_done <= 1'b1;
          aw_addr <= AWADDR;
        end
        if (w_fire) begin
          w_done <= 1'b1;
          w_data <= WDATA;
          w_strb <= WSTRB;
        end
      end
    end else if (BREADY) begin
      BVALID  <= 1'b0;
      w_state <= W_IDLE;
    end
  end

  // r_val reads the register array before any same-edge write lands, so a
  // read racing a write to the same index returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_fire) begin
        RVALID  <= 1'b1;
        RDATA   <= r_val;
        RRESP   <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        r_state <= R_DATA;
      end
    end else if (RREADY) begin
      RVALID  <= 1'b0;
      r_state <= R_IDLE;
    end
  end

endmodule

// File: tb/tb_axi4l_slave_regfile.sv
// Self-checking bench for axi4l_slave_regfile (defaults, RO_MASK=0x1).
module tb_axi4l_slave_regfile;

  logic         clk;
  logic         rst;
  logic [7:0]   AWADDR;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [7:0]   ARADDR;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [511:0] regs_o;
  logic [511:0] ro;

  axi4l_slave_regfile #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_REGS(16),
    .RO_MASK(16'h0001)
  ) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .ro_i(ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] model [16];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  function automatic logic [511:0] pack_model();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Reference byte-merge: index 0 is read-only, indices >= 16 are out of range.
  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= 1 && idx < 16)
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int   n;
    logic a;
    logic w;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    resp = 2'b11;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      @(negedge clk); a = AWREADY; w = WREADY;
      @(posedge clk); #1;
      if (a) AWVALID = 1'b0;
      if (w) WVALID = 1'b0;
      n++;
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (BVALID) break;
      n++;
    end
    if (n >= 20) begin
      timeout_fail("write_resp");
      AWVALID = 1'b0; WVALID = 1'b0;
    end else begin
      resp = BRESP;
    end
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [1:0] resp, output logic [31:0] data);
    int   n;
    logic a;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    resp = 2'b11; data = 32'hx;
    n = 0;
    while (ARVALID && n < 20) begin
      @(negedge clk); a = ARREADY;
      @(posedge clk); #1;
      if (a) ARVALID = 1'b0;
      n++;
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (RVALID) break;
      n++;
    end
    if (n >= 20) begin
      timeout_fail("read_data");
      ARVALID = 1'b0;
    end else begin
      resp = RRESP; data = RDATA;
    end
    @(posedge clk); #1;
    RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 8'h0D, 32'h00AB0000, 4'h4, 2'b00, 32'h0};
    vecs[2]  = '{1'b1, 8'h0C, 32'h11111111, 4'h0, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'hFFABFFFF};
    vecs[4]  = '{1'b1, 8'h40, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, 8'h00, 32'h00000001, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 8'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 8'h3F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 8'hFF, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[11] = '{1'b1, 8'h20, 32'h00000080, 4'h1, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 8'h20, 32'h0,        4'h0, 2'b00, 32'h00000080};

    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    ro = '0;
    ro[31:0]  = 32'hA5A5A5A5;
    ro[63:32] = 32'h11111111;

    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state and ready release timing
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_rresp", RRESP, 2'b00);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_regs", regs_o, 512'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_awready_early", AWREADY, 1'b0);
    @(negedge clk);
    check("rel_awready", AWREADY, 1'b1);
    check("rel_wready", WREADY, 1'b1);
    check("rel_arready", ARREADY, 1'b1);
    @(posedge clk); #1;

    // Table-driven single transactions
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_regs", i), regs_o, pack_model());
      end else begin
        axi_read(vecs[i].addr, resp, rd);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      end
    end

    // Same-cycle AW/W, then B and R held off for 5 cycles
    AWADDR = 8'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
    @(negedge clk);
    check("h1_awready", AWREADY, 1'b1);
    check("h1_wready", WREADY, 1'b1);
    check("h1_bvalid_pre", BVALID, 1'b0);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h04; ARVALID = 1'b1;
    @(negedge clk);
    check("h1_bvalid", BVALID, 1'b1);
    check("h1_bresp", BRESP, 2'b00);
    check("h1_reg1", regs_o[63:32], 32'hDEADBEEF);
    check("h1_arready", ARREADY, 1'b1);
    model[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    AWADDR = 8'h10; WDATA = 32'h55555555; ARADDR = 8'h10;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_bvalid", c), BVALID, 1'b1);
      check($sformatf("hold%0d_bresp", c), BRESP, 2'b00);
      check($sformatf("hold%0d_rvalid", c), RVALID, 1'b1);
      check($sformatf("hold%0d_rdata", c), RDATA, 32'hDEADBEEF);
      check($sformatf("hold%0d_rresp", c), RRESP, 2'b00);
      check($sformatf("hold%0d_readies", c), {AWREADY, WREADY, ARREADY}, 3'b000);
      @(posedge clk); #1;
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    @(negedge clk);
    check("h1_bvalid_done", BVALID, 1'b0);
    check("h1_rvalid_done", RVALID, 1'b0);
    check("h1_readies_back", {AWREADY, WREADY, ARREADY}, 3'b111);
    check("h1_regs", regs_o, pack_model());
    @(posedge clk); #1;

    // W leads AW by 3 cycles, partial strobe over 0xFFFFFFFF
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
    model[2] = 32'hFFFFFFFF;
    WDATA = 32'h12345678; WSTRB = 4'h3; WVALID = 1'b1; BREADY = 1'b1;
    @(negedge clk);
    check("h2_wready", WREADY, 1'b1);
    @(posedge clk); #1;
    WVALID = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("h2_wait%0d", c), {WREADY, AWREADY, BVALID}, 3'b010);
      @(posedge clk); #1;
    end
    AWADDR = 8'h08; AWVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    @(negedge clk);
    check("h2_bvalid", BVALID, 1'b1);
    check("h2_bresp", BRESP, 2'b00);
    check("h2_reg2", regs_o[95:64], 32'hFFFF5678);
    model[2] = 32'hFFFF5678;
    @(posedge clk); #1;
    BREADY = 1'b0;
    @(negedge clk);
    check("h2_bvalid_done", BVALID, 1'b0);
    @(posedge clk); #1;

    // Read accepted on the same edge a write to the same index commits
    AWADDR = 8'h14; WDATA = 32'h00000077; WSTRB = 4'hF; ARADDR = 8'h14;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(negedge clk);
    check("h3_rvalid", RVALID, 1'b1);
    check("h3_rdata_old", RDATA, 32'h0);
    check("h3_reg5_new", regs_o[191:160], 32'h00000077);
    check("h3_bvalid", BVALID, 1'b1);
    model[5] = 32'h77;
    @(posedge clk); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    check("h3_regs", regs_o, pack_model());

    // Reset while BVALID is high, then reset with only W captured
    AWADDR = 8'h18; WDATA = 32'h99; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    check("h4_bvalid", BVALID, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("h4_bvalid_rst", BVALID, 1'b0);
    check("h4_regs_rst", regs_o, 512'h0);
    check("h4_awready_rst", AWREADY, 1'b0);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("h4_awready_early", AWREADY, 1'b0);
    @(negedge clk);
    check("h4_awready_rel", AWREADY, 1'b1);
    @(posedge clk); #1;
    WDATA = 32'hAAAAAAAA; WVALID = 1'b1;
    @(posedge clk); #1;
    WVALID = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    AWADDR = 8'h1C; AWVALID = 1'b1; BREADY = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("h4_abort%0d_bvalid", c), BVALID, 1'b0);
      check($sformatf("h4_abort%0d_regs", c), regs_o, pack_model());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
